// File: rtl/interrupt_source_unit_pkg.sv
// Shared constants for the interrupt source unit: register map, mip bit positions, timer type.
package interrupt_source_unit_pkg;

  localparam int unsigned AddrMsip       = 32'h0000;
  localparam int unsigned AddrMtimecmpLo = 32'h4000;
  localparam int unsigned AddrMtimecmpHi = 32'h4004;
  localparam int unsigned AddrMtimeLo    = 32'hBFF8;
  localparam int unsigned AddrMtimeHi    = 32'hBFFC;

  localparam int unsigned IrqSsip = 1;
  localparam int unsigned IrqMsip = 3;
  localparam int unsigned IrqStip = 5;
  localparam int unsigned IrqMtip = 7;
  localparam int unsigned IrqSeip = 9;
  localparam int unsigned IrqMeip = 11;
  localparam int unsigned NumIrq  = 12;

  typedef logic [63:0] mtime_t;

endpackage

// File: rtl/int_sync_ff.sv
// Flop-chain synchroniser for one asynchronous level input; Depth flops from d_i to q_o.
module int_sync_ff #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/interrupt_source_unit.sv
// Machine timer, msip, S-level pending bits and external lines -> registered mip-format vector.
// INT_SRC_EXT_SYNC_EN selects a 2-flop external-line synchroniser instead of a single capture flop.
module interrupt_source_unit
  import interrupt_source_unit_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_data,
  output logic              o_resp_err,
  input  logic              i_ext_irq_m,
  input  logic              i_ext_irq_s,
  input  logic              i_sip_we,
  input  logic [11:0]       i_sip_wdata,
  output logic [11:0]       o_intp,
  output logic [63:0]       o_mtime
);

`ifdef INT_SRC_EXT_SYNC_EN
  localparam int unsigned SyncDepth = 2;
`else
  localparam int unsigned SyncDepth = 1;
`endif
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mtime_t            mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [PreW-1:0]   presc_q, presc_d;
  logic              msip_q, msip_d, ssip_q, ssip_d, stip_q, stip_d, seip_sw_q, seip_sw_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0]       resp_data_q, resp_data_d, rdata;
  logic              rerr;
  logic [NumIrq-1:0] intp_q, intp_d;
  logic              ext_m_sync, ext_s_sync;
  logic              acc, tick;
  logic              sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic              unused_sip_wdata;

  int_sync_ff #(.Depth(SyncDepth)) u_sync_m (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_ext_irq_m),
    .q_o    (ext_m_sync)
  );

  int_sync_ff #(.Depth(SyncDepth)) u_sync_s (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_ext_irq_s),
    .q_o    (ext_s_sync)
  );

  assign o_req_ready  = ~resp_valid_q | i_resp_ready;
  assign acc          = i_req_valid & o_req_ready;
  assign tick         = (presc_q == PreW'(TICK_DIV - 1));
  assign sel_msip     = (i_req_addr == ADDR_W'(AddrMsip));
  assign sel_cmp_lo   = (i_req_addr == ADDR_W'(AddrMtimecmpLo));
  assign sel_cmp_hi   = (i_req_addr == ADDR_W'(AddrMtimecmpHi));
  assign sel_mtime_lo = (i_req_addr == ADDR_W'(AddrMtimeLo));
  assign sel_mtime_hi = (i_req_addr == ADDR_W'(AddrMtimeHi));
  assign unused_sip_wdata = ^{i_sip_wdata[11:10], i_sip_wdata[8:6], i_sip_wdata[4:2],
                              i_sip_wdata[0]};

  // Read data reflects pre-write, pre-increment register values.
  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    if (sel_msip)          rdata = {31'b0, msip_q};
    else if (sel_cmp_lo)   rdata = mtimecmp_q[31:0];
    else if (sel_cmp_hi)   rdata = mtimecmp_q[63:32];
    else if (sel_mtime_lo) rdata = mtime_q[31:0];
    else if (sel_mtime_hi) rdata = mtime_q[63:32];
    else                   rerr  = 1'b1;
  end

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    mtime_d      = mtime_q + mtime_t'(tick);
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    ssip_d       = ssip_q;
    stip_d       = stip_q;
    seip_sw_d    = seip_sw_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    // A write to one mtime half replaces the tick for that cycle; no carry into the other half.
    if (acc && i_req_we) begin
      if (sel_mtime_lo) mtime_d = {mtime_q[63:32], i_req_wdata};
      if (sel_mtime_hi) mtime_d = {i_req_wdata, mtime_q[31:0]};
      if (sel_cmp_lo)   mtimecmp_d[31:0]  = i_req_wdata;
      if (sel_cmp_hi)   mtimecmp_d[63:32] = i_req_wdata;
      if (sel_msip)     msip_d = i_req_wdata[0];
    end

    if (i_sip_we) begin
      ssip_d    = i_sip_wdata[IrqSsip];
      stip_d    = i_sip_wdata[IrqStip];
      seip_sw_d = i_sip_wdata[IrqSeip];
    end

    if (acc) begin
      resp_valid_d = 1'b1;
      resp_data_d  = i_req_we ? '0 : rdata;
      resp_err_d   = rerr;
    end else if (i_resp_ready) begin
      resp_valid_d = 1'b0;
    end

    intp_d          = '0;
    intp_d[IrqSsip] = ssip_d;
    intp_d[IrqMsip] = msip_d;
    intp_d[IrqStip] = stip_d;
    intp_d[IrqMtip] = (mtime_d >= mtimecmp_d);
    intp_d[IrqSeip] = seip_sw_d | ext_s_sync;
    intp_d[IrqMeip] = ext_m_sync;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      ssip_q       <= 1'b0;
      stip_q       <= 1'b0;
      seip_sw_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      intp_q       <= '0;
    end else begin
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      ssip_q       <= ssip_d;
      stip_q       <= stip_d;
      seip_sw_q    <= seip_sw_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      intp_q       <= intp_d;
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_resp_data  = resp_data_q;
  assign o_resp_err   = resp_err_q;
  assign o_intp       = intp_q;
  assign o_mtime      = mtime_q;

endmodule

// File: tb/tb_interrupt_source_unit.sv
// Scoreboard bench for interrupt_source_unit: directed scenarios then randomized traffic.
module tb_interrupt_source_unit;

  localparam int unsigned TD = 4;
`ifdef INT_SRC_EXT_SYNC_EN
  localparam int unsigned SD = 2;
`else
  localparam int unsigned SD = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_req_valid, i_req_we, i_resp_ready;
  logic [15:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_ext_irq_m, i_ext_irq_s, i_sip_we;
  logic [11:0] i_sip_wdata;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_data;
  logic [11:0] o_intp;
  logic [63:0] o_mtime;

  always #5 i_clk = ~i_clk;

  interrupt_source_unit #(.TICK_DIV(TD), .ADDR_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_resp_err   (o_resp_err),
    .i_ext_irq_m  (i_ext_irq_m),
    .i_ext_irq_s  (i_ext_irq_s),
    .i_sip_we     (i_sip_we),
    .i_sip_wdata  (i_sip_wdata),
    .o_intp       (o_intp),
    .o_mtime      (o_mtime)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];

  // Reference model: architectural state advanced once per clock from the sampled inputs.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_ssip, m_stip, m_seip, m_resp_valid;
  logic [11:0] m_intp;
  int unsigned m_cyc;
  logic        hm[3], hs[3];
  logic        m_ready, m_acc, m_tick, m_rerr;
  logic [31:0] m_rv;
  resp_t       m_r, mon_r;

  always @(negedge i_clk) begin : model
    if (!i_rst_n) begin
      chk("rst_intp", 64'(o_intp), 64'(0));
      chk("rst_resp_valid", 64'(o_resp_valid), 64'(0));
      m_mtime = 0; m_cmp = '1; m_msip = 0; m_ssip = 0; m_stip = 0; m_seip = 0;
      m_resp_valid = 0; m_intp = 0; m_cyc = 0;
      for (int i = 0; i < 3; i++) begin hm[i] = 0; hs[i] = 0; end
      exp_q.delete();
    end else begin
      m_ready = !m_resp_valid || i_resp_ready;
      chk("intp", 64'(o_intp), 64'(m_intp));
      chk("mtime", o_mtime, m_mtime);
      chk("resp_valid", 64'(o_resp_valid), 64'(m_resp_valid));
      chk("req_ready", 64'(o_req_ready), 64'(m_ready));

      m_acc  = i_req_valid && m_ready;
      m_tick = (m_cyc % TD) == TD - 1;
      m_cyc++;
      m_rv = 0; m_rerr = 0;
      case (i_req_addr)
        16'h0000: m_rv = {31'b0, m_msip};
        16'h4000: m_rv = m_cmp[31:0];
        16'h4004: m_rv = m_cmp[63:32];
        16'hBFF8: m_rv = m_mtime[31:0];
        16'hBFFC: m_rv = m_mtime[63:32];
        default:  m_rerr = 1;
      endcase
      if (m_acc) begin
        m_r.data = i_req_we ? 32'h0 : m_rv;
        m_r.err  = m_rerr;
        exp_q.push_back(m_r);
      end
      if (m_acc && i_req_we && i_req_addr == 16'hBFF8)      m_mtime[31:0]  = i_req_wdata;
      else if (m_acc && i_req_we && i_req_addr == 16'hBFFC) m_mtime[63:32] = i_req_wdata;
      else if (m_tick)                                       m_mtime = m_mtime + 1;
      if (m_acc && i_req_we && i_req_addr == 16'h4000) m_cmp[31:0]  = i_req_wdata;
      if (m_acc && i_req_we && i_req_addr == 16'h4004) m_cmp[63:32] = i_req_wdata;
      if (m_acc && i_req_we && i_req_addr == 16'h0000) m_msip = i_req_wdata[0];
      if (m_acc) m_resp_valid = 1;
      else if (i_resp_ready) m_resp_valid = 0;
      if (i_sip_we) begin
        m_ssip = i_sip_wdata[1];
        m_stip = i_sip_wdata[5];
        m_seip = i_sip_wdata[9];
      end
      hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = i_ext_irq_m;
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = i_ext_irq_s;
      m_intp     = 0;
      m_intp[1]  = m_ssip;
      m_intp[3]  = m_msip;
      m_intp[5]  = m_stip;
      m_intp[7]  = (m_mtime >= m_cmp);
      m_intp[9]  = m_seip | hs[SD];
      m_intp[11] = hm[SD];
    end
  end

  // Monitor: a presented response must match the oldest expectation; popped when consumed.
  always @(negedge i_clk) begin : monitor
    if (i_rst_n && o_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_expected", 64'(exp_q.size() != 0), 64'(1));
      end else begin
        mon_r = exp_q[0];
        chk("resp_data", 64'(o_resp_data), 64'(mon_r.data));
        chk("resp_err", 64'(o_resp_err), 64'(mon_r.err));
        if (i_resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wd);
    int  n = 0;
    bit  done = 0;
    i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_wdata = wd;
    while (!done) begin
      @(negedge i_clk);
      done = o_req_ready;
      @(posedge i_clk);
      #1;
      n++;
      if (!done && n > 100) begin
        chk("req_accept_timeout", 64'(done), 64'(1));
        done = 1;
      end
    end
    i_req_valid = 0;
  endtask

  logic [15:0] addrs[6] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_resp_ready = 1;
    i_ext_irq_m = 0; i_ext_irq_s = 0; i_sip_we = 0; i_sip_wdata = 0;
    #1 i_rst_n = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1;

    do_req(0, 16'h4000, 0);
    do_req(0, 16'h4004, 0);

    do_req(1, 16'h4000, 10);
    do_req(1, 16'h4004, 0);
    do_req(1, 16'hBFFC, 0);
    do_req(1, 16'hBFF8, 0);
    n = 0;
    while (!o_intp[7] && n < 100) begin idle(1); n++; end
    chk("mtip_rise", 64'(o_intp[7]), 64'(1));
    do_req(1, 16'h4004, 1);
    chk("mtip_clear", 64'(o_intp[7]), 64'(0));

    do_req(1, 16'h0000, 1);
    chk("msip_set", 64'(o_intp), 64'h008);
    do_req(1, 16'h0000, 0);
    chk("msip_clr", 64'(o_intp), 64'h000);

    // Stalled response: request port must stay closed until the response is taken.
    idle(1);
    i_resp_ready = 0;
    do_req(0, 16'hBFF8, 0);
    i_req_valid = 1; i_req_we = 0; i_req_addr = 16'h4000;
    idle(4);
    chk("req_ready_stalled", 64'(o_req_ready), 64'(0));
    i_resp_ready = 1;
    do_req(0, 16'h4000, 0);
    idle(1);

    i_ext_irq_s = 1;
    idle(4);
    i_sip_we = 1; i_sip_wdata = 12'h222;
    idle(1);
    i_sip_we = 0;
    chk("sip_set", 64'(o_intp), 64'h222);
    i_sip_we = 1; i_sip_wdata = 12'h000;
    idle(1);
    i_sip_we = 0;
    chk("seip_ext_hold", 64'(o_intp), 64'h200);
    i_ext_irq_s = 0;
    idle(4);

    do_req(0, 16'h1234, 0);
    chk("unmapped_err", 64'(o_resp_err), 64'(1));
    chk("unmapped_data", 64'(o_resp_data), 64'(0));

    do_req(1, 16'hBFFC, 32'hFFFF_FFFF);
    do_req(1, 16'hBFF8, 32'hFFFF_FFFF);
    idle(TD + 2);
    chk("mtime_wrapped", 64'(o_mtime <= 64'd1), 64'(1));

    i_ext_irq_m = 1;
    idle(SD);
    chk("meip_latency_early", 64'(o_intp[11]), 64'(0));
    idle(1);
    chk("meip_latency", 64'(o_intp[11]), 64'(1));
    i_ext_irq_m = 0;
    idle(4);

    // Reset while a response is pending and a write is waiting to be accepted.
    i_resp_ready = 0;
    do_req(0, 16'hBFF8, 0);
    i_req_valid = 1; i_req_we = 1; i_req_addr = 16'h0000; i_req_wdata = 1;
    idle(2);
    #3;
    i_rst_n = 0; i_req_valid = 0;
    idle(2);
    i_rst_n = 1; i_resp_ready = 1;
    idle(2);
    chk("msip_after_reset", 64'(o_intp[3]), 64'(0));

    for (int i = 0; i < 400; i++) begin
      i_req_valid  = 1'($urandom_range(0, 1));
      i_req_we     = 1'($urandom_range(0, 1));
      i_req_addr   = addrs[$urandom_range(0, 5)];
      i_req_wdata  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 60)) : $urandom();
      i_resp_ready = ($urandom_range(0, 3) != 0);
      i_sip_we     = ($urandom_range(0, 4) == 0);
      i_sip_wdata  = 12'($urandom());
      if ($urandom_range(0, 9) == 0) i_ext_irq_m = ~i_ext_irq_m;
      if ($urandom_range(0, 9) == 0) i_ext_irq_s = ~i_ext_irq_s;
      idle(1);
    end

    i_req_valid = 0; i_sip_we = 0; i_resp_ready = 1;
    idle(5);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
